// File: rtl/digit_glyph_reader_pkg.sv
// Shared definitions for the digit glyph reader: 5x5 font, no-match code, FSM states.
package digit_glyph_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_MATCH   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [3:0] NO_MATCH = 4'hF;

  // Rows 0..4 concatenated, row 0 in the MSBs, leftmost column is the row MSB.
  localparam logic [24:0] FONT_0 = 25'b01110_10001_10001_10001_01110;
  localparam logic [24:0] FONT_1 = 25'b00100_01100_00100_00100_01110;
  localparam logic [24:0] FONT_2 = 25'b11110_00001_01110_10000_11111;
  localparam logic [24:0] FONT_3 = 25'b11110_00001_00110_00001_11110;
  localparam logic [24:0] FONT_4 = 25'b10010_10010_11111_00010_00010;
  localparam logic [24:0] FONT_5 = 25'b11111_10000_11110_00001_11110;
  localparam logic [24:0] FONT_6 = 25'b01110_10000_11110_10001_01110;
  localparam logic [24:0] FONT_7 = 25'b11111_00001_00010_00100_00100;
  localparam logic [24:0] FONT_8 = 25'b01110_10001_01110_10001_01110;
  localparam logic [24:0] FONT_9 = 25'b01110_10001_01111_00001_01110;

  function automatic logic [24:0] font_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return FONT_0;
      4'd1:    return FONT_1;
      4'd2:    return FONT_2;
      4'd3:    return FONT_3;
      4'd4:    return FONT_4;
      4'd5:    return FONT_5;
      4'd6:    return FONT_6;
      4'd7:    return FONT_7;
      4'd8:    return FONT_8;
      default: return FONT_9;
    endcase
  endfunction

endpackage

// File: rtl/digit_glyph_reader_glyph_match.sv
// Exact 25-bit compare of one captured bitmap against the ten font glyphs.
module glyph_match
  import digit_glyph_reader_pkg::*;
(
  input  logic [24:0] bitmap,
  output logic [3:0]  code,
  output logic        hit
);

  // Font entries are unique, so at most one compare can fire.
  always_comb begin
    code = NO_MATCH;
    hit  = 1'b0;
    for (int d = 0; d < 10; d++) begin
      if (bitmap == font_glyph(4'(d))) begin
        code = 4'(d);
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/digit_glyph_reader.sv
// Captures NDIG 5x5 glyph cells from the pixel stream once per frame and
// reports the recognised digit codes with a one-cycle valid pulse.
module digit_glyph_reader
  import digit_glyph_reader_pkg::*;
#(
  parameter int X0         = 0,
  parameter int Y0         = 0,
  parameter int NDIG       = 4,
  parameter int SCALE_LOG2 = 0,
  parameter int COL_OFS    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          hpos,
  input  logic [10:0]          vpos,
  input  logic                 display_on,
  input  logic                 pixel,
  output logic                 valid,
  output logic [4*NDIG-1:0]    digits,
  output logic [NDIG-1:0]      hit,
  output logic                 abort
);

  localparam int HALF = (1 << SCALE_LOG2) >> 1;
  localparam int MASK = (1 << SCALE_LOG2) - 1;

  state_t                   state_q, state_d;
  logic [NDIG-1:0][24:0]    bmp_q, bmp_d;
  logic [2:0]               idx_q, idx_d;
  logic [NDIG-1:0][3:0]     stg_code_q, stg_code_d;
  logic [NDIG-1:0]          stg_hit_q, stg_hit_d;
  logic [4*NDIG-1:0]        digits_q, digits_d;
  logic [NDIG-1:0]          hit_q, hit_d;
  logic                     valid_q, valid_d;
  logic                     abort_q, abort_d;

  int          dy, dx, row, col, cidx, smp_k;
  logic        smp_hit, smp_last, smp_val, store_en, frame_start;
  logic [4:0]  smp_bit;
  logic [24:0] m_bmp;
  logic [3:0]  m_code;
  logic        m_hit;

  // Decode whether the current (hpos, vpos) is a glyph sample point, and which bit it feeds.
  always_comb begin
    dy       = int'(vpos) - (Y0 + HALF);
    dx       = int'(hpos) - (X0 + HALF);
    row      = dy >>> SCALE_LOG2;
    col      = dx >>> SCALE_LOG2;
    cidx     = (col & 7) - COL_OFS;
    smp_k    = col >>> 3;
    smp_hit  = (dy >= 0) && ((dy & MASK) == 0) && (row < 5) &&
               (dx >= 0) && ((dx & MASK) == 0) &&
               (cidx >= 0) && (cidx < 5) && (smp_k < NDIG);
    smp_last = smp_hit && (row == 4) && (cidx == 4) && (smp_k == NDIG - 1);
    smp_bit  = 5'(24 - (5 * row + cidx));
  end

  assign smp_val     = pixel & display_on;
  assign frame_start = (hpos == 11'd0) && (int'(vpos) == Y0);

  // Select the bitmap for the current MATCH cycle.
  always_comb begin
    m_bmp = '0;
    for (int k = 0; k < NDIG; k++)
      if (idx_q == 3'(k)) m_bmp = bmp_q[k];
  end

  glyph_match u_match (
    .bitmap (m_bmp),
    .code   (m_code),
    .hit    (m_hit)
  );

  // Next-state logic: capture samples, step through the matcher, publish results.
  always_comb begin
    state_d    = state_q;
    bmp_d      = bmp_q;
    idx_d      = idx_q;
    stg_code_d = stg_code_q;
    stg_hit_d  = stg_hit_q;
    digits_d   = digits_q;
    hit_d      = hit_q;
    valid_d    = 1'b0;
    abort_d    = 1'b0;
    store_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d  = S_CAPTURE;
          bmp_d    = '0;
          store_en = 1'b1;  // a sample may coincide with the frame start
        end
      end
      S_CAPTURE: begin
        if (int'(vpos) < Y0) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else begin
          store_en = 1'b1;
          if (smp_last) begin
            state_d = S_MATCH;
            idx_d   = '0;
          end
        end
      end
      S_MATCH: begin
        for (int k = 0; k < NDIG; k++) begin
          if (idx_q == 3'(k)) begin
            stg_code_d[k] = m_code;
            stg_hit_d[k]  = m_hit;
          end
        end
        idx_d = idx_q + 3'd1;
        // Results land in the output registers on entry to DONE, so valid,
        // digits and hit all appear together in the DONE cycle.
        if (idx_q == 3'(NDIG - 1)) begin
          state_d  = S_DONE;
          digits_d = stg_code_d;
          hit_d    = stg_hit_d;
          valid_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (store_en && smp_hit) begin
      for (int k = 0; k < NDIG; k++)
        if (smp_k == k) bmp_d[k][smp_bit] = smp_val;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bmp_q      <= '0;
      idx_q      <= '0;
      stg_code_q <= '0;
      stg_hit_q  <= '0;
      digits_q   <= '1;
      hit_q      <= '0;
      valid_q    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bmp_q      <= bmp_d;
      idx_q      <= idx_d;
      stg_code_q <= stg_code_d;
      stg_hit_q  <= stg_hit_d;
      digits_q   <= digits_d;
      hit_q      <= hit_d;
      valid_q    <= valid_d;
      abort_q    <= abort_d;
    end
  end

  assign valid  = valid_q;
  assign abort  = abort_q;
  assign digits = digits_q;
  assign hit    = hit_q;

endmodule

// File: tb/tb_digit_glyph_reader.sv
// Directed bench: a default-geometry reader (A) and a 4x-scaled, offset,
// single-cell reader (B) watch the same small raster.
module tb_digit_glyph_reader;

  localparam int H = 96;
  localparam int V = 48;
  localparam int X0B = 32;
  localparam int Y0B = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hpos = '0, vpos = '0;
  logic        display_on = 1'b0, pix_a = 1'b0, pix_b = 1'b0;
  logic        val_a, abt_a, val_b, abt_b;
  logic [15:0] dig_a;
  logic [3:0]  hit_a;
  logic [3:0]  dig_b;
  logic [0:0]  hit_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  digit_glyph_reader u_a (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .pixel(pix_a), .valid(val_a), .digits(dig_a), .hit(hit_a), .abort(abt_a)
  );

  digit_glyph_reader #(.X0(X0B), .Y0(Y0B), .NDIG(1), .SCALE_LOG2(2), .COL_OFS(3)) u_b (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .pixel(pix_b), .valid(val_b), .digits(dig_b), .hit(hit_b), .abort(abt_b)
  );

  function automatic logic [24:0] tb_font(input int d);
    case (d)
      0: return 25'b01110_10001_10001_10001_01110;
      1: return 25'b00100_01100_00100_00100_01110;
      2: return 25'b11110_00001_01110_10000_11111;
      3: return 25'b11110_00001_00110_00001_11110;
      4: return 25'b10010_10010_11111_00010_00010;
      5: return 25'b11111_10000_11110_00001_11110;
      6: return 25'b01110_10000_11110_10001_01110;
      7: return 25'b11111_00001_00010_00100_00100;
      8: return 25'b01110_10001_01110_10001_01110;
      default: return 25'b01110_10001_01111_00001_01110;
    endcase
  endfunction

  // Reader A: cells at x=0, 1 screen pixel per font pixel, glyph in columns 3..7.
  function automatic logic render_a(input int h, input int v, input logic [15:0] dg, input bit flip);
    int k, c;
    logic [24:0] g;
    logic b;
    if (v < 0 || v >= 5 || h < 0 || h >= 32) return 1'b0;
    k = h / 8;
    c = (h % 8) - 3;
    if (c < 0 || c > 4) return 1'b0;
    g = tb_font(int'(dg[4*k +: 4]));
    b = g[24 - (5*v + c)];
    if (flip && k == 2 && v == 2 && c == 0) b = ~b;
    return b;
  endfunction

  // Reader B: glyph '7' drawn 4x at (32,16); only font-pixel centres are clean.
  function automatic logic render_b(input int h, input int v);
    int dx, dy, c, r;
    logic [24:0] g;
    dx = h - X0B;
    dy = v - Y0B;
    if (dx < 0 || dx >= 32 || dy < 0 || dy >= 20) return 1'b0;
    if ((dx % 4) != 2 || (dy % 4) != 2) return 1'($urandom_range(1, 0));
    c = dx / 4 - 3;
    r = dy / 4;
    if (c < 0 || c > 4) return 1'($urandom_range(1, 0));
    g = tb_font(7);
    return g[24 - (5*r + c)];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One raster frame. abort_v >= 0 forces vpos to 0 from hpos 40 of that row and ends the frame.
  // rst_match pulses reset in the second MATCH cycle of reader A.
  task automatic run_frame(input logic [15:0] dg, input bit flip, input int abort_v, input bit rst_match,
                           output int va_n, output int va_d, output int vb_n, output int vb_d,
                           output int ab_n, output int ab_d, output int aa_n, output int excl);
    int it, la, lb, ai, va_at, vb_at, ab_at, vv;
    bit stop;
    it = 0; la = -100; lb = -100; ai = -1; va_at = -1; vb_at = -1; ab_at = -1;
    va_n = 0; vb_n = 0; ab_n = 0; aa_n = 0; excl = 0; stop = 0;
    for (int v = 0; v < V && !stop; v++) begin
      for (int h = 0; h < H; h++) begin
        vv = v;
        if (abort_v == v && h >= 40) begin
          vv = 0;
          if (ai < 0) ai = it;
        end
        hpos = 11'(h);
        vpos = 11'(vv);
        display_on = (h < 80) && (vv < 44);
        pix_a = render_a(h, vv, dg, flip);
        pix_b = render_b(h, vv);
        if (vv == 4 && h == 31) la = it;
        if (vv == 34 && h == 62) lb = it;
        reset = (rst_match && it == la + 2);
        @(posedge clk);
        #1;
        if (val_a) begin va_n++; va_at = it; end
        if (val_b) begin vb_n++; vb_at = it; end
        if (abt_b) begin ab_n++; ab_at = it; end
        if (abt_a) aa_n++;
        if ((val_a && abt_a) || (val_b && abt_b)) excl++;
        it++;
      end
      if (abort_v == v) stop = 1;
    end
    reset = 1'b0;
    va_d = va_at - la;
    vb_d = vb_at - lb;
    ab_d = ab_at - ai;
  endtask

  initial begin
    int va_n, va_d, vb_n, vb_d, ab_n, ab_d, aa_n, excl, excl_tot;
    excl_tot = 0;
    if (X0B + ((8 * 1) << 2) > 2047)
      $fatal(1, "reader B geometry exceeds the hpos range");

    // Reset for three cycles
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(val_a), 32'd0);
    chk("rst_abort", 32'(abt_a), 32'd0);
    chk("rst_digits", 32'(dig_a), 32'h0000FFFF);
    chk("rst_hit", 32'(hit_a), 32'h0);
    chk("rst_digits_b", 32'(dig_b), 32'hF);
    chk("rst_hit_b", 32'(hit_b), 32'h0);

    // Frame 1: 0,1,2,3 in A; noisy 4x '7' in B
    run_frame(16'h3210, 0, -1, 0, va_n, va_d, vb_n, vb_d, ab_n, ab_d, aa_n, excl);
    excl_tot += excl;
    chk("f1_valid_cnt", 32'(va_n), 32'd1);
    chk("f1_latency", 32'(va_d), 32'd4);
    chk("f1_digits", 32'(dig_a), 32'h3210);
    chk("f1_hit", 32'(hit_a), 32'hF);
    chk("f1_abort_a", 32'(aa_n), 32'd0);
    chk("f1_b_valid_cnt", 32'(vb_n), 32'd1);
    chk("f1_b_latency", 32'(vb_d), 32'd1);
    chk("f1_b_digit", 32'(dig_b), 32'h7);
    chk("f1_b_hit", 32'(hit_b), 32'h1);

    // Frame 2: cell 2 draws '8' with row 2 column 0 flipped
    run_frame(16'h3810, 1, -1, 0, va_n, va_d, vb_n, vb_d, ab_n, ab_d, aa_n, excl);
    excl_tot += excl;
    chk("f2_valid_cnt", 32'(va_n), 32'd1);
    chk("f2_digits", 32'(dig_a), 32'h3F10);
    chk("f2_hit", 32'(hit_a), 32'hB);

    // Frame 3: vpos jumps to 0 during B's capture, after its row 2
    run_frame(16'h3210, 0, 28, 0, va_n, va_d, vb_n, vb_d, ab_n, ab_d, aa_n, excl);
    excl_tot += excl;
    chk("f3_b_abort_cnt", 32'(ab_n), 32'd1);
    chk("f3_b_abort_lat", 32'(ab_d), 32'd0);
    chk("f3_b_no_valid", 32'(vb_n), 32'd0);
    chk("f3_b_digit_held", 32'(dig_b), 32'h7);
    chk("f3_b_hit_held", 32'(hit_b), 32'h1);
    chk("f3_a_digits", 32'(dig_a), 32'h3210);

    // Frame 4: B recovers on a full frame
    run_frame(16'h3210, 0, -1, 0, va_n, va_d, vb_n, vb_d, ab_n, ab_d, aa_n, excl);
    excl_tot += excl;
    chk("f4_b_valid_cnt", 32'(vb_n), 32'd1);
    chk("f4_b_abort_cnt", 32'(ab_n), 32'd0);
    chk("f4_b_digit", 32'(dig_b), 32'h7);

    // Frame 5: reset during A's MATCH cycle 2
    run_frame(16'h9854, 0, -1, 1, va_n, va_d, vb_n, vb_d, ab_n, ab_d, aa_n, excl);
    excl_tot += excl;
    chk("f5_no_valid", 32'(va_n), 32'd0);
    chk("f5_digits_rst", 32'(dig_a), 32'h0000FFFF);
    chk("f5_hit_rst", 32'(hit_a), 32'h0);
    chk("f5_b_digit", 32'(dig_b), 32'h7);

    // Frame 6: A recaptures a new pattern
    run_frame(16'h9854, 0, -1, 0, va_n, va_d, vb_n, vb_d, ab_n, ab_d, aa_n, excl);
    excl_tot += excl;
    chk("f6_valid_cnt", 32'(va_n), 32'd1);
    chk("f6_latency", 32'(va_d), 32'd4);
    chk("f6_digits", 32'(dig_a), 32'h9854);
    chk("f6_hit", 32'(hit_a), 32'hF);

    chk("valid_abort_excl", 32'(excl_tot), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
